// File: rtl/branch_pkg.sv
// branch_pkg: types and helpers shared by the branch resolution slice.
//   INSTR_BYTES    - instruction size; the fall-through PC is pc + INSTR_BYTES.
//   ENTRY_PC_WIDTH - width of the PC fields stored per in-flight branch.
//                    The top's PC_WIDTH must not exceed this.
//   branch_entry_t - one tracked branch: {pc, pred, target}.
//   pc_to_index    - predictor index of a word-aligned PC (PC >> 2).
//                    The caller truncates the result to ADDR_WIDTH bits,
//                    which yields PC[ADDR_WIDTH+1:2].
package branch_pkg;

  localparam int INSTR_BYTES    = 4;
  localparam int ENTRY_PC_WIDTH = 32;

  typedef struct packed {
    logic [ENTRY_PC_WIDTH-1:0] pc;
    logic                      pred;
    logic [ENTRY_PC_WIDTH-1:0] target;
  } branch_entry_t;

  function automatic logic [ENTRY_PC_WIDTH-1:0] pc_to_index(
    input logic [ENTRY_PC_WIDTH-1:0] pc
  );
    return pc >> $clog2(INSTR_BYTES);
  endfunction

endpackage

// File: rtl/branch_tracker_fifo.sv
// branch_tracker_fifo: in-order FIFO of in-flight branch records.
//   clk   - clock, rising edge
//   rst   - synchronous active-low reset (empties the FIFO)
//   push  - write din at the tail. The caller only pushes when
//           count < DEPTH.
//   pop   - drop the head entry. The caller only pops when count > 0.
//   clear - empty the FIFO. Overrides push and pop in the same cycle.
//   din   - entry to push
//   head  - oldest entry. The read is combinational because the
//           resolve compare needs it in the same cycle.
//   count - current occupancy, 0..DEPTH
module branch_tracker_fifo
  import branch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  branch_entry_t            din,
  output branch_entry_t            head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_WIDTH = $clog2(DEPTH);
  localparam int CNT_WIDTH = PTR_WIDTH + 1;

  branch_entry_t        mem [DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr_reg;
  logic [PTR_WIDTH-1:0] rd_ptr_reg;
  logic [CNT_WIDTH-1:0] count_reg;

  // DEPTH is a power of two, so the pointers wrap without any compare.
  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_WIDTH'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_WIDTH'(1);
      count_reg <= count_reg + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
    end
  end

  // The storage has no reset. An entry is only read after it has been
  // pushed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= din;
  end

  assign head  = mem[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/branch_resolution_unit.sv
// branch_resolution_unit: tracks fetched branch predictions and matches
// them against in-order resolutions. It trains the predictor, raises a
// flush on a mispredict, and counts branches and mispredicts.
//   clk, rst                       - clock; synchronous active-low reset
//   fetchValid/PC/Prediction/Target - branch predicted at fetch
//   fetchReady                     - tracker has room (registered occupancy)
//   resolveValid/Taken/Target      - resolution of the oldest in-flight branch
//   updateAddr/branchTaken/update  - predictor training strobe, one cycle
//   flush/redirectPC               - mispredict flush and corrected PC, one cycle
//   inFlight                       - current tracker occupancy
//   branchCount/mispredictCount    - saturating statistics
module branch_resolution_unit
  import branch_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int PC_WIDTH   = 32,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fetchValid,
  input  logic [PC_WIDTH-1:0]    fetchPC,
  input  logic                   fetchPrediction,
  input  logic [PC_WIDTH-1:0]    fetchTarget,
  output logic                   fetchReady,
  input  logic                   resolveValid,
  input  logic                   resolveTaken,
  input  logic [PC_WIDTH-1:0]    resolveTarget,
  output logic [ADDR_WIDTH-1:0]  updateAddr,
  output logic                   branchTaken,
  output logic                   update,
  output logic                   flush,
  output logic [PC_WIDTH-1:0]    redirectPC,
  output logic [$clog2(DEPTH):0] inFlight,
  output logic [CNT_WIDTH-1:0]   branchCount,
  output logic [CNT_WIDTH-1:0]   mispredictCount
);

  localparam int OCC_WIDTH = $clog2(DEPTH) + 1;

  branch_entry_t         fetch_entry;
  branch_entry_t         head;
  logic                  push;
  logic                  pop;
  logic                  mispredict;
  logic [PC_WIDTH-1:0]   head_pc;
  logic [PC_WIDTH-1:0]   head_target;
  logic [PC_WIDTH-1:0]   redirect_next;

  logic                  update_reg;
  logic [ADDR_WIDTH-1:0] update_addr_reg;
  logic                  branch_taken_reg;
  logic                  flush_reg;
  logic [PC_WIDTH-1:0]   redirect_pc_reg;
  logic [CNT_WIDTH-1:0]  branch_count_reg;
  logic [CNT_WIDTH-1:0]  mispredict_count_reg;

  // Readiness comes only from registered occupancy. A pop in the same
  // cycle does not open a slot early.
  assign fetchReady = inFlight < OCC_WIDTH'(DEPTH);

  always_comb begin
    head_pc     = PC_WIDTH'(head.pc);
    head_target = PC_WIDTH'(head.target);
    pop         = resolveValid && (inFlight != '0);
    // A wrong direction, or a correct taken prediction with the wrong target.
    mispredict  = pop && ((head.pred != resolveTaken) ||
                          (resolveTaken && head.pred && (head_target != resolveTarget)));
    // Fetches on the mispredict edge and during the flush cycle are wrong-path.
    push        = fetchValid && fetchReady && !mispredict && !flush_reg;
    redirect_next = resolveTaken ? resolveTarget
                                 : head_pc + PC_WIDTH'(INSTR_BYTES);
    fetch_entry = '{pc:     ENTRY_PC_WIDTH'(fetchPC),
                    pred:   fetchPrediction,
                    target: ENTRY_PC_WIDTH'(fetchTarget)};
  end

  branch_tracker_fifo #(
    .DEPTH (DEPTH)
  ) u_tracker (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clear (mispredict),
    .din   (fetch_entry),
    .head  (head),
    .count (inFlight)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      update_reg           <= 1'b0;
      update_addr_reg      <= '0;
      branch_taken_reg     <= 1'b0;
      flush_reg            <= 1'b0;
      redirect_pc_reg      <= '0;
      branch_count_reg     <= '0;
      mispredict_count_reg <= '0;
    end else begin
      update_reg <= pop;
      flush_reg  <= mispredict;
      if (pop) begin
        update_addr_reg  <= ADDR_WIDTH'(pc_to_index(head.pc));
        branch_taken_reg <= resolveTaken;
        if (branch_count_reg != '1)
          branch_count_reg <= branch_count_reg + CNT_WIDTH'(1);
      end
      // On a correct prediction the redirect PC keeps its last value.
      if (mispredict) begin
        redirect_pc_reg <= redirect_next;
        if (mispredict_count_reg != '1)
          mispredict_count_reg <= mispredict_count_reg + CNT_WIDTH'(1);
      end
    end
  end

  assign update          = update_reg;
  assign updateAddr      = update_addr_reg;
  assign branchTaken     = branch_taken_reg;
  assign flush           = flush_reg;
  assign redirectPC      = redirect_pc_reg;
  assign branchCount     = branch_count_reg;
  assign mispredictCount = mispredict_count_reg;

endmodule

// File: tb/tb_branch_resolution_unit.sv
// Bench for branch_resolution_unit. Two instances share the stimulus: one
// with default parameters, and one with CNT_WIDTH=2 for counter saturation.
// A queue-based model follows the branch rules and is compared against
// the DUT every cycle. Literal expectations pin the directed scenarios.
module tb_branch_resolution_unit;

  localparam int AW = 6;
  localparam int PW = 32;
  localparam int D  = 4;
  localparam int CW = 16;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          fetchValid = 1'b0;
  logic [PW-1:0] fetchPC = '0;
  logic          fetchPrediction = 1'b0;
  logic [PW-1:0] fetchTarget = '0;
  logic          resolveValid = 1'b0;
  logic          resolveTaken = 1'b0;
  logic [PW-1:0] resolveTarget = '0;

  logic          fetchReady, update, branchTaken, flush;
  logic [AW-1:0] updateAddr;
  logic [PW-1:0] redirectPC;
  logic [2:0]    inFlight;
  logic [CW-1:0] branchCount, mispredictCount;

  logic          s_fetchReady, s_update, s_branchTaken, s_flush;
  logic [AW-1:0] s_updateAddr;
  logic [PW-1:0] s_redirectPC;
  logic [2:0]    s_inFlight;
  logic [SW-1:0] s_branchCount, s_mispredictCount;

  branch_resolution_unit u_dut (
    .clk(clk), .rst(rst),
    .fetchValid(fetchValid), .fetchPC(fetchPC), .fetchPrediction(fetchPrediction),
    .fetchTarget(fetchTarget), .fetchReady(fetchReady),
    .resolveValid(resolveValid), .resolveTaken(resolveTaken), .resolveTarget(resolveTarget),
    .updateAddr(updateAddr), .branchTaken(branchTaken), .update(update),
    .flush(flush), .redirectPC(redirectPC), .inFlight(inFlight),
    .branchCount(branchCount), .mispredictCount(mispredictCount)
  );

  branch_resolution_unit #(.CNT_WIDTH(SW)) u_sat (
    .clk(clk), .rst(rst),
    .fetchValid(fetchValid), .fetchPC(fetchPC), .fetchPrediction(fetchPrediction),
    .fetchTarget(fetchTarget), .fetchReady(s_fetchReady),
    .resolveValid(resolveValid), .resolveTaken(resolveTaken), .resolveTarget(resolveTarget),
    .updateAddr(s_updateAddr), .branchTaken(s_branchTaken), .update(s_update),
    .flush(s_flush), .redirectPC(s_redirectPC), .inFlight(s_inFlight),
    .branchCount(s_branchCount), .mispredictCount(s_mispredictCount)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [PW-1:0] pc;
    bit            pred;
    logic [PW-1:0] tgt;
  } ent_t;

  ent_t          mq[$];
  bit            m_update, m_taken, m_flush;
  logic [AW-1:0] m_addr;
  logic [PW-1:0] m_redirect;
  int unsigned   m_bc, m_mc;

  int checks   = 0;
  int failures = 0;

  function automatic longint unsigned satv(int unsigned v, int w);
    longint unsigned mx = (64'd1 << w) - 1;
    return (longint'(v) > mx) ? mx : longint'(v);
  endfunction

  // Advances the model by one clock edge, using the inputs currently driven.
  task automatic model_step();
    bit   do_pop, mis, prev_flush, do_push;
    ent_t h;
    if (!rst) begin
      mq.delete();
      m_update = 0; m_taken = 0; m_flush = 0;
      m_addr = '0; m_redirect = '0; m_bc = 0; m_mc = 0;
      return;
    end
    prev_flush = m_flush;
    do_pop = resolveValid && (mq.size() > 0);
    mis = 0;
    m_update = do_pop;
    if (do_pop) begin
      h = mq[0];
      m_addr  = AW'(h.pc / 4);
      m_taken = resolveTaken;
      mis = (h.pred != resolveTaken) || (resolveTaken && h.tgt != resolveTarget);
      m_bc++;
      if (mis) begin
        m_mc++;
        m_redirect = resolveTaken ? resolveTarget : PW'(h.pc + 4);
      end
    end
    m_flush = mis;
    do_push = fetchValid && (mq.size() < D) && !mis && !prev_flush;
    if (mis) mq.delete();
    else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back('{pc: fetchPC, pred: fetchPrediction, tgt: fetchTarget});
    end
  endtask

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("inFlight",   64'(inFlight),   64'(mq.size()));
    chk("fetchReady", 64'(fetchReady), 64'(mq.size() < D));
    chk("update",     64'(update),     64'(m_update));
    chk("flush",      64'(flush),      64'(m_flush));
    if (m_update) begin
      chk("updateAddr",  64'(updateAddr),  64'(m_addr));
      chk("branchTaken", 64'(branchTaken), 64'(m_taken));
    end
    if (m_flush) chk("redirectPC", 64'(redirectPC), 64'(m_redirect));
    chk("branchCount",       64'(branchCount),       satv(m_bc, CW));
    chk("mispredictCount",   64'(mispredictCount),   satv(m_mc, CW));
    chk("sat_branchCount",   64'(s_branchCount),     satv(m_bc, SW));
    chk("sat_mispredictCnt", 64'(s_mispredictCount), satv(m_mc, SW));
  endtask

  // One clock: drive the inputs, step the model, then compare at the next
  // falling edge.
  task automatic cyc(bit r, bit fv, logic [PW-1:0] pc, bit pr, logic [PW-1:0] tg,
                     bit rv, bit rt, logic [PW-1:0] rtg);
    rst = r; fetchValid = fv; fetchPC = pc; fetchPrediction = pr; fetchTarget = tg;
    resolveValid = rv; resolveTaken = rt; resolveTarget = rtg;
    model_step();
    @(negedge clk);
    compare_all();
    $display("cyc t=%0t rst=%0b fv=%0b pc=%h rv=%0b rt=%0b -> occ=%0d upd=%0b addr=%h flush=%0b redir=%h bc=%0d mc=%0d",
             $time, r, fv, pc, rv, rt, inFlight, update, updateAddr, flush, redirectPC,
             branchCount, mispredictCount);
  endtask

  task automatic idle();
    cyc(1, 0, '0, 0, '0, 0, 0, '0);
  endtask

  initial begin
    logic [PW-1:0] rpc, rtg;
    bit            rr;

    // Reset held for two cycles while fetchValid is high.
    cyc(0, 1, 32'h40, 1, 32'h80, 0, 0, '0);
    cyc(0, 1, 32'h40, 1, 32'h80, 0, 0, '0);
    chk("lit_reset_inFlight", 64'(inFlight), 0);
    chk("lit_reset_ready",    64'(fetchReady), 1);
    chk("lit_reset_update",   64'(update), 0);
    chk("lit_reset_flush",    64'(flush), 0);
    chk("lit_reset_bc",       64'(branchCount), 0);

    // Correct taken prediction.
    cyc(1, 1, 32'h40, 1, 32'h80, 0, 0, '0);
    cyc(1, 0, '0, 0, '0, 1, 1, 32'h80);
    chk("lit_ok_update", 64'(update), 1);
    chk("lit_ok_addr",   64'(updateAddr), 64'h10);
    chk("lit_ok_taken",  64'(branchTaken), 1);
    chk("lit_ok_flush",  64'(flush), 0);
    chk("lit_ok_bc",     64'(branchCount), 1);
    chk("lit_ok_mc",     64'(mispredictCount), 0);
    chk("model_ok_addr", 64'(m_addr), 64'h10);
    idle();

    // Direction mispredict with two younger wrong-path entries.
    cyc(1, 1, 32'h100, 0, 32'h0,   0, 0, '0);
    cyc(1, 1, 32'h104, 1, 32'h180, 0, 0, '0);
    cyc(1, 1, 32'h108, 0, 32'h0,   0, 0, '0);
    cyc(1, 0, '0, 0, '0, 1, 1, 32'h200);
    chk("lit_dir_flush",    64'(flush), 1);
    chk("lit_dir_redirect", 64'(redirectPC), 64'h200);
    chk("lit_dir_inFlight", 64'(inFlight), 0);
    chk("lit_dir_mc",       64'(mispredictCount), 1);
    chk("lit_dir_addr",     64'(updateAddr), 64'h00);
    chk("lit_dir_taken",    64'(branchTaken), 1);
    chk("model_dir_redirect", 64'(m_redirect), 64'h200);
    idle();
    chk("lit_dir_flush_drop", 64'(flush), 0);

    // Not-taken mispredict.
    cyc(1, 1, 32'h3C, 1, 32'h90, 0, 0, '0);
    cyc(1, 0, '0, 0, '0, 1, 0, 32'h0);
    chk("lit_nt_flush",    64'(flush), 1);
    chk("lit_nt_redirect", 64'(redirectPC), 64'h40);
    chk("lit_nt_addr",     64'(updateAddr), 64'h0F);
    chk("lit_nt_taken",    64'(branchTaken), 0);
    // The fetch during the flush cycle must be dropped.
    cyc(1, 1, 32'h44, 0, 32'h0, 0, 0, '0);
    chk("lit_flush_cycle_drop", 64'(inFlight), 0);

    // Fill the tracker, overflow it, push and pop together at full, drain.
    for (int i = 0; i < 4; i++) cyc(1, 1, PW'(32'h200 + 4 * i), 0, '0, 0, 0, '0);
    chk("lit_full_ready", 64'(fetchReady), 0);
    chk("lit_full_occ",   64'(inFlight), 4);
    cyc(1, 1, 32'h300, 0, '0, 0, 0, '0);
    chk("lit_full_drop",  64'(inFlight), 4);
    cyc(1, 1, 32'h304, 0, '0, 1, 0, '0);
    chk("lit_full_pushpop", 64'(inFlight), 3);
    for (int i = 0; i < 3; i++) cyc(1, 0, '0, 0, '0, 1, 0, '0);
    chk("lit_drained", 64'(inFlight), 0);
    cyc(1, 0, '0, 0, '0, 1, 1, 32'h10);
    chk("lit_empty_no_update", 64'(update), 0);
    chk("lit_empty_bc",        64'(branchCount), 7);

    // Target mispredict, then a fourth mispredict to saturate the small counter.
    cyc(1, 1, 32'h500, 1, 32'h80, 0, 0, '0);
    cyc(1, 0, '0, 0, '0, 1, 1, 32'h84);
    chk("lit_tgt_flush",    64'(flush), 1);
    chk("lit_tgt_redirect", 64'(redirectPC), 64'h84);
    idle();
    cyc(1, 1, 32'h600, 0, '0, 0, 0, '0);
    cyc(1, 0, '0, 0, '0, 1, 1, 32'h700);
    chk("lit_sat_mc",     64'(s_mispredictCount), 3);
    chk("lit_sat_bc",     64'(s_branchCount), 3);
    chk("lit_full_mc",    64'(mispredictCount), 4);
    idle();

    // Reset mid-operation: entries discarded, no update or flush after it.
    cyc(1, 1, 32'h800, 1, 32'h900, 0, 0, '0);
    cyc(1, 1, 32'h804, 0, 32'h0,   0, 0, '0);
    cyc(0, 0, '0, 0, '0, 1, 0, '0);
    chk("lit_midrst_occ",    64'(inFlight), 0);
    chk("lit_midrst_update", 64'(update), 0);
    cyc(1, 0, '0, 0, '0, 1, 0, '0);
    chk("lit_midrst_after",  64'(update), 0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      rr  = ($urandom_range(0, 299) != 0);
      rpc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      if (mq.size() > 0 && $urandom_range(0, 3) != 0) rtg = mq[0].tgt;
      else rtg = $urandom & 32'hFFFF_FFFC;
      cyc(rr, $urandom_range(0, 1) == 1, rpc, $urandom_range(0, 1) == 1,
          $urandom & 32'hFFFF_FFFC, $urandom_range(0, 9) < 4,
          $urandom_range(0, 1) == 1, rtg);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
